// File: rtl/tester_pkg.sv
// rtl/tester_pkg.sv - shared types and constants for the tester cycle sequencer
package tester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int MIN_CYCLE_LENGTH = 2;
    localparam int DEFAULT_NUM_CH   = 8;
    localparam int DEFAULT_ADDR_W   = 8;

endpackage

// File: rtl/tester_cycle_timer.sv
// rtl/tester_cycle_timer.sv - 1..N wrap counter with prefetch (N-1) and end (N) strobes
module tester_cycle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] length,
    output logic       at_prefetch,
    output logic       at_end
);

    logic [7:0] count;

    // Count starts at 1 so it lines up with the channel-side counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd1;
        end else if (load) begin
            count <= 8'd1;
        end else if (en) begin
            count <= at_end ? 8'd1 : count + 8'd1;
        end
    end

    assign at_end      = en && (count == length);
    assign at_prefetch = en && (count == length - 8'd1);

endmodule

// File: rtl/tester_cycle_ctrl.sv
// rtl/tester_cycle_ctrl.sv - pattern sequencer for force-format channels; TESTER_LOOP_EN adds looping
module tester_cycle_ctrl
    import tester_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic [7:0]        CYCLE_LENGTH,
    input  logic [ADDR_W-1:0] VEC_COUNT,
`ifdef TESTER_LOOP_EN
    input  logic [7:0]        LOOP_COUNT,
`endif
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [NUM_CH-1:0] MEM_DATA,
    output logic [NUM_CH-1:0] PIN_D,
    output logic              PIN_EN,
    output logic              PIN_RST,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] VEC_INDEX
);

    state_t            state, next_state;
    logic [7:0]        cycle_len_q;
    logic [ADDR_W-1:0] vec_count_q;
    logic              stop_pend;
    logic              at_prefetch, at_end;
    logic              params_ok, accept, reject;
    logic              last_vec, loop_more, finish, advance;

    assign params_ok = (CYCLE_LENGTH >= 8'(MIN_CYCLE_LENGTH)) && (VEC_COUNT != '0);
    assign accept    = (state == IDLE) && START && !STOP && params_ok;
    assign reject    = (state == IDLE) && START && !STOP && !params_ok;
    assign last_vec  = (VEC_INDEX == vec_count_q - ADDR_W'(1));
    // A STOP arriving on the boundary edge itself still ends the run there.
    assign finish    = stop_pend || STOP || (last_vec && !loop_more);
    assign advance   = (state == RUN) && at_end && !finish;

`ifdef TESTER_LOOP_EN
    logic [7:0] loop_count_q, loops_done;

    assign loop_more = (loops_done < loop_count_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            loop_count_q <= 8'd0;
            loops_done   <= 8'd0;
        end else if (accept) begin
            loop_count_q <= LOOP_COUNT;
            loops_done   <= 8'd0;
        end else if (advance && last_vec) begin
            loops_done   <= loops_done + 8'd1;
        end
    end
`else
    assign loop_more = 1'b0;
`endif

    tester_cycle_timer u_timer (
        .clk         (CLK),
        .rst         (RST),
        .load        (state == LOAD),
        .en          (state == RUN),
        .length      (cycle_len_q),
        .at_prefetch (at_prefetch),
        .at_end      (at_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN:     if (at_end && finish) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        BUSY    = (state != IDLE);
        PIN_EN  = (state == RUN);
        PIN_RST = (state != RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_len_q <= 8'd0;
            vec_count_q <= '0;
            MEM_ADDR    <= '0;
            PIN_D       <= '0;
            VEC_INDEX   <= '0;
            stop_pend   <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            DONE <= (state == RUN) && at_end && finish;
            ERR  <= reject;
            if (accept) begin
                cycle_len_q <= CYCLE_LENGTH;
                vec_count_q <= VEC_COUNT;
                MEM_ADDR    <= '0;
            end
            if (state == LOAD) begin
                PIN_D     <= MEM_DATA;
                VEC_INDEX <= '0;
            end
            // Prefetch one CLK ahead of the boundary so MEM_DATA is ready on it.
            if ((state == RUN) && at_prefetch) begin
                MEM_ADDR <= (last_vec && loop_more) ? '0 : VEC_INDEX + ADDR_W'(1);
            end
            if (advance) begin
                PIN_D     <= MEM_DATA;
                VEC_INDEX <= last_vec ? '0 : VEC_INDEX + ADDR_W'(1);
            end
            if (next_state == IDLE)
                stop_pend <= 1'b0;
            else if ((state == RUN) && STOP)
                stop_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tester_cycle_ctrl.sv
// tb/tb_tester_cycle_ctrl.sv - self-checking bench for tester_cycle_ctrl against a timeline model
module tb_tester_cycle_ctrl;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 8;
`ifdef TESTER_LOOP_EN
    localparam bit LOOP_BUILD = 1'b1;
`else
    localparam bit LOOP_BUILD = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              START = 1'b0;
    logic              STOP = 1'b0;
    logic [7:0]        CYCLE_LENGTH = 8'd0;
    logic [ADDR_W-1:0] VEC_COUNT = '0;
    logic [7:0]        LOOP_COUNT = 8'd0;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [NUM_CH-1:0] MEM_DATA;
    logic [NUM_CH-1:0] PIN_D;
    logic              PIN_EN, PIN_RST, BUSY, DONE, ERR;
    logic [ADDR_W-1:0] VEC_INDEX;

    logic [NUM_CH-1:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    assign MEM_DATA = mem[MEM_ADDR];

    always #5 CLK = ~CLK;

    tester_cycle_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .STOP         (STOP),
        .CYCLE_LENGTH (CYCLE_LENGTH),
        .VEC_COUNT    (VEC_COUNT),
`ifdef TESTER_LOOP_EN
        .LOOP_COUNT   (LOOP_COUNT),
`endif
        .MEM_ADDR     (MEM_ADDR),
        .MEM_DATA     (MEM_DATA),
        .PIN_D        (PIN_D),
        .PIN_EN       (PIN_EN),
        .PIN_RST      (PIN_RST),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERR          (ERR),
        .VEC_INDEX    (VEC_INDEX)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pin_rst"}, 32'(PIN_RST), 32'd1);
        chk({tag, ".pin_en"},  32'(PIN_EN),  32'd0);
        chk({tag, ".pin_d"},   32'(PIN_D),   32'd0);
        chk({tag, ".mem_addr"}, 32'(MEM_ADDR), 32'd0);
        chk({tag, ".vec_index"}, 32'(VEC_INDEX), 32'd0);
        chk({tag, ".busy"}, 32'(BUSY), 32'd0);
        chk({tag, ".done"}, 32'(DONE), 32'd0);
        chk({tag, ".err"},  32'(ERR),  32'd0);
    endtask

    // s counts edges after the accepting edge. Vector k is on the pins for
    // s in [1+k*L, (k+1)*L]; DONE follows at s = n*L+1. A STOP sampled at
    // edge e >= 2 lets the vector in progress finish: n = (e-2)/L + 1.
    task automatic run(input string tag, input int L, input int VC, input int LC, input int stop_e);
        int n, span, k, exp_v;
        n = LOOP_BUILD ? VC * (LC + 1) : VC;
        if (stop_e >= 2 && (stop_e - 2) / L + 1 < n) n = (stop_e - 2) / L + 1;
        span = n * L;
        START = 1'b1;
        CYCLE_LENGTH = 8'(L);
        VEC_COUNT = ADDR_W'(VC);
        LOOP_COUNT = 8'(LC);
        tick();
        START = 1'b0;
        for (int s = 0; s <= span + 2; s++) begin
            k = (s == 0) ? 0 : (((s <= span) ? s : span) - 1) / L;
            exp_v = k % VC;
            if (s == 0) begin
                chk({tag, ".load_busy"}, 32'(BUSY), 32'd1);
                chk({tag, ".load_en"}, 32'(PIN_EN), 32'd0);
                chk({tag, ".load_rst"}, 32'(PIN_RST), 32'd1);
                chk({tag, ".load_addr"}, 32'(MEM_ADDR), 32'd0);
            end else if (s <= span) begin
                chk({tag, ".run_busy"}, 32'(BUSY), 32'd1);
                chk({tag, ".run_en"}, 32'(PIN_EN), 32'd1);
                chk({tag, ".run_rst"}, 32'(PIN_RST), 32'd0);
                chk({tag, ".run_pin_d"}, 32'(PIN_D), 32'(mem[exp_v]));
                chk({tag, ".run_vec_index"}, 32'(VEC_INDEX), 32'(exp_v));
            end else begin
                chk({tag, ".idle_busy"}, 32'(BUSY), 32'd0);
                chk({tag, ".idle_en"}, 32'(PIN_EN), 32'd0);
                chk({tag, ".idle_rst"}, 32'(PIN_RST), 32'd1);
                chk({tag, ".idle_pin_d"}, 32'(PIN_D), 32'(mem[exp_v]));
                chk({tag, ".idle_vec_index"}, 32'(VEC_INDEX), 32'(exp_v));
            end
            chk({tag, ".done"}, 32'(DONE), (s == span + 1) ? 32'd1 : 32'd0);
            chk({tag, ".err"}, 32'(ERR), 32'd0);
            // Stray START and parameter churn while busy must be ignored.
            STOP = (s + 1 == stop_e);
            START = (s <= span) ? 1'($urandom_range(0, 1)) : 1'b0;
            CYCLE_LENGTH = 8'($urandom_range(0, 255));
            VEC_COUNT = ADDR_W'($urandom_range(0, 255));
            if (s < span + 2) tick();
        end
        START = 1'b0;
        STOP = 1'b0;
    endtask

    task automatic err_try(input string tag, input int L, input int VC, input logic stp, input logic exp_err);
        START = 1'b1;
        STOP = stp;
        CYCLE_LENGTH = 8'(L);
        VEC_COUNT = ADDR_W'(VC);
        tick();
        START = 1'b0;
        STOP = 1'b0;
        chk({tag, ".err"}, 32'(ERR), 32'(exp_err));
        chk({tag, ".busy"}, 32'(BUSY), 32'd0);
        tick();
        chk({tag, ".err_clear"}, 32'(ERR), 32'd0);
        chk({tag, ".busy_after"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int L, VC, LC, se;
        for (int i = 0; i < 256; i++) mem[i] = NUM_CH'($urandom);

        RST = 1'b1;
        tick();
        tick();
        chk_reset_vals("reset");
        RST = 1'b0;
        tick();

        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        mem[2] = 8'hFF;
        run("basic", 4, 3, 0, 0);

        err_try("cl1", 1, 3, 1'b0, 1'b1);
        err_try("cl0", 0, 3, 1'b0, 1'b1);
        err_try("vc0", 4, 0, 1'b0, 1'b1);
        err_try("start_stop", 4, 3, 1'b1, 1'b0);
        err_try("start_stop_bad", 1, 0, 1'b1, 1'b0);

        run("stop", 6, 10, 0, 21);
        run("after_stop", 3, 2, 0, 0);
        run("cl2", 2, 4, 0, 0);
        run("stop_load", 3, 2, 0, 1);
        run("stop_edge", 3, 4, 0, 7);

        START = 1'b1;
        CYCLE_LENGTH = 8'd5;
        VEC_COUNT = 8'd6;
        tick();
        START = 1'b0;
        repeat (12) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_reset_vals("mid_reset");
        run("post_reset", 3, 3, 0, 0);

        run("loop", 3, 2, 2, 0);
        run("loop_stop", 3, 3, 1, 12);

        for (int r = 0; r < 8; r++) begin
            L = $urandom_range(2, 7);
            VC = $urandom_range(1, 12);
            LC = $urandom_range(0, 2);
            se = ($urandom_range(0, 2) == 0) ? $urandom_range(1, VC * L) : 0;
            run("rand", L, VC, LC, se);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
